// File: rtl/port_serializer.sv
// Packet FIFO behind the input-port deserializer that re-serializes each queued
// packet onto the frame_n/valid_n/data link, so router stages can be cascaded.
module port_serializer #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vld,
    input  logic [3:0]        addr,
    input  logic [31:0]       payload,
    output logic              clear,
    output logic              dout,
    output logic              frameo_n,
    output logic              valido_n,
    output logic              full,
    output logic              empty,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, PAY, GAP} state_t;

    state_t        r_state;
    logic [35:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [3:0]    r_addr_sr;
    logic [31:0]   r_pay_sr;
    logic [5:0]    r_cnt;
    logic          r_hold;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_count_nxt;
    logic [35:0]   w_head;

    // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
    assign w_pop       = (r_state == IDLE) && !empty && !r_hold;
    assign w_push      = vld && (!full || w_pop);
    assign w_drop      = vld && full && !w_pop;
    assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_head      = r_mem[r_rptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= {addr, payload};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            clear    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            clear <= vld;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            full    <= (w_count_nxt == FULL_CNT);
            empty   <= (w_count_nxt == '0);
            if (w_drop && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // r_hold forces one plain IDLE cycle after GAP, giving a 39-cycle frame period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hold    <= 1'b0;
            r_addr_sr <= '0;
            r_pay_sr  <= '0;
            dout      <= 1'b0;
            frameo_n  <= 1'b1;
            valido_n  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    dout     <= 1'b0;
                    frameo_n <= 1'b1;
                    valido_n <= 1'b1;
                    r_hold   <= 1'b0;
                    if (w_pop) begin
                        r_addr_sr <= w_head[35:32];
                        r_pay_sr  <= w_head[31:0];
                        r_cnt     <= '0;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    dout      <= r_addr_sr[0];
                    r_addr_sr <= {1'b0, r_addr_sr[3:1]};
                    frameo_n  <= 1'b0;
                    valido_n  <= 1'b1;
                    if (r_cnt == 6'd3) begin
                        r_cnt   <= '0;
                        r_state <= PAY;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                PAY: begin
                    dout     <= r_pay_sr[0];
                    r_pay_sr <= {1'b0, r_pay_sr[31:1]};
                    valido_n <= 1'b0;
                    frameo_n <= (r_cnt == 6'd31);
                    if (r_cnt == 6'd31) begin
                        r_cnt   <= '0;
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                GAP: begin
                    dout     <= 1'b0;
                    frameo_n <= 1'b1;
                    valido_n <= 1'b1;
                    r_hold   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
